// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream handshake (in_data/in_valid/in_ready) and memory write bus (mem_we/mem_addr/mem_wdata)
interface instr_mem_loader_if;
  logic [7:0] in_data;
  logic in_valid, in_ready, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  modport master (output in_data, in_valid, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: framed byte stream (bus) -> 16-bit instruction memory writes (bus); start arms, busy/done/error/words_written report status
module instr_mem_loader #(
  parameter int DEPTH = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  instr_mem_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic error,
  output logic [15:0] words_written
);
  typedef enum logic [3:0] {IDLE, SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [15:0] n_q, n_d, addr_q, addr_d, wdata_q, wdata_d, ww_q, ww_d;
  logic [7:0] hi_q, hi_d, chk_q, chk_d;
  logic xfer;
  assign bus.in_ready = state_q inside {SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
  assign bus.mem_we = state_q == WRITE;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy = !(state_q inside {IDLE, DONE, ERR});
  assign done = state_q == DONE;
  assign error = state_q == ERR;
  assign words_written = ww_q;
  assign xfer = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    ww_d = ww_q;
    hi_d = hi_q;
    chk_d = chk_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = SYNC;
        ww_d = '0;
        chk_d = '0;
        addr_d = '0;
      end
      SYNC: if (xfer && bus.in_data == SYNC_BYTE) state_d = LEN_HI;
      LEN_HI: if (xfer) begin
        n_d = {bus.in_data, 8'h00};
        chk_d = chk_q ^ bus.in_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        n_d = {n_q[15:8], bus.in_data};
        chk_d = chk_q ^ bus.in_data;
        state_d = n_d > 16'(DEPTH) ? ERR : n_d == 16'd0 ? CHK : DATA_HI;
      end
      DATA_HI: if (xfer) begin
        hi_d = bus.in_data;
        chk_d = chk_q ^ bus.in_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (xfer) begin
        wdata_d = {hi_q, bus.in_data};
        chk_d = chk_q ^ bus.in_data;
        state_d = WRITE;
      end
      WRITE: begin
        addr_d = addr_q + 16'd1;
        ww_d = ww_q + 16'd1;
        state_d = ww_d < n_q ? DATA_HI : CHK;
      end
      CHK: if (xfer) state_d = bus.in_data == chk_q ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      ww_q <= '0;
      hi_q <= '0;
      chk_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ww_q <= ww_d;
      hi_q <= hi_d;
      chk_q <= chk_d;
    end
  end
endmodule
